// File: rtl/traffic_sensor_interface.sv
// -----------------------------------------------------------------------------
// traffic_sensor_interface
//   Country-road vehicle sensing front end. Conditions the arrival and
//   departure inductive loops, keeps a waiting-vehicle count and drives the
//   car-present request x towards the traffic signal controller, releasing it
//   when the queue empties or after MAX_SERVE cycles of green service.
//
// Ports
//   clk        system clock
//   clear_n    asynchronous active-low reset
//   arr_raw    arrival loop, asynchronous, high = vehicle over loop
//   dep_raw    departure loop (stop line), asynchronous
//   crd        country-road light: 0=RED 1=YELLOW 2=GREEN 3=invalid
//   x          registered vehicle request
//   queue_cnt  registered waiting-vehicle count
//   overflow   sticky, an arrival was dropped at a full queue
//   red_run    one-cycle pulse, departure seen while crd was RED
// -----------------------------------------------------------------------------

// Per-loop conditioning: 2-flop synchronizer, debounce, rising-edge event.
module traffic_sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic clear_n,
    input  logic raw,
    output logic rise
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    logic          lvl, lvl_q;
    logic [DW-1:0] db_cnt;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            lvl    <= 1'b0;
            lvl_q  <= 1'b0;
            db_cnt <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            lvl_q <= lvl;
            // Count consecutive edges where the synced sample disagrees with
            // the debounced level; the edge that completes the run flips it.
            if (s2 != lvl) begin
                if (db_cnt == DB_LAST) begin
                    lvl    <= s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign rise = lvl & ~lvl_q;
endmodule

module traffic_sensor_interface #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4,
    parameter int MAX_SERVE       = 32
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             arr_raw,
    input  logic             dep_raw,
    input  logic [1:0]       crd,
    output logic             x,
    output logic [CNT_W-1:0] queue_cnt,
    output logic             overflow,
    output logic             red_run
);
    localparam int TW = (MAX_SERVE > 1) ? $clog2(MAX_SERVE) : 1;
    localparam logic [TW-1:0]    TMR_LAST  = TW'(MAX_SERVE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [1:0]       CRD_RED   = 2'd0;
    localparam logic [1:0]       CRD_GREEN = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, SERVE, DRAIN} state_t;

    state_t        state, nstate;
    logic [TW-1:0] tmr;
    logic          x_d;
    logic [1:0]    raw, rise;
    logic          arr_ev, dep_ev;

    // Channel 0 = arrival loop, channel 1 = departure loop.
    assign raw = {dep_raw, arr_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        traffic_sensor_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .clear_n(clear_n),
            .raw    (raw[ch]),
            .rise   (rise[ch])
        );
    end

    assign arr_ev = rise[0];
    assign dep_ev = rise[1];

    // Queue counter, overflow flag and red-run detector.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            queue_cnt <= '0;
            overflow  <= 1'b0;
            red_run   <= 1'b0;
        end else begin
            red_run <= dep_ev && (crd == CRD_RED);
            if (arr_ev && !dep_ev) begin
                if (queue_cnt == CNT_MAX) overflow  <= 1'b1;
                else                      queue_cnt <= queue_cnt + CNT_W'(1);
            end else if (dep_ev && !arr_ev && queue_cnt != '0) begin
                queue_cnt <= queue_cnt - CNT_W'(1);
            end
        end
    end

    // Request FSM: state register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) state <= IDLE;
        else          state <= nstate;
    end

    // Request FSM: next-state logic.
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (queue_cnt != '0) nstate = REQ;
            REQ:     if (crd == CRD_GREEN) nstate = SERVE;
            SERVE:   if (queue_cnt == '0 || tmr == TMR_LAST) nstate = DRAIN;
            DRAIN:   if (crd == CRD_RED) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Request FSM: output decode, taken from the next state so x is a flop.
    always_comb begin
        x_d = (nstate == REQ) || (nstate == SERVE);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) x <= 1'b0;
        else          x <= x_d;
    end

    // Serve timer: held at zero while requesting so SERVE always starts at 0.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)                             tmr <= '0;
        else if (state == REQ)                    tmr <= '0;
        else if (state == SERVE && nstate == SERVE) tmr <= tmr + TW'(1);
    end
endmodule

// File: tb/tb_traffic_sensor_interface.sv
module tb_traffic_sensor_interface;
    localparam int D  = 4;
    localparam int CW = 4;
    localparam int MS = 32;
    localparam int P_IDLE = 0, P_REQ = 1, P_SERVE = 2, P_DRAIN = 3;

    logic          clk = 1'b0;
    logic          clear_n = 1'b0;
    logic          arr_raw = 1'b0;
    logic          dep_raw = 1'b0;
    logic [1:0]    crd = 2'd0;
    logic          x, overflow, red_run;
    logic [CW-1:0] queue_cnt;

    traffic_sensor_interface #(
        .DEBOUNCE_CYCLES(D), .CNT_W(CW), .MAX_SERVE(MS)
    ) dut (
        .clk(clk), .clear_n(clear_n), .arr_raw(arr_raw), .dep_raw(dep_raw),
        .crd(crd), .x(x), .queue_cnt(queue_cnt), .overflow(overflow),
        .red_run(red_run)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic x;
        int   cnt;
        logic ovf;
        logic rr;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model state
    logic s1a, s2a, s1d, s2d;     // two-stage sample delay of each loop
    logic deba, debd, preva, prevd;
    logic ha[$], hd[$];           // recent delayed samples, newest last
    int   mcnt, ph, serve_age;
    logic movf, mrr;

    task automatic check(input string nm, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    endtask

    // A level flips once its last D delayed samples all disagree with it.
    function automatic logic window_level(input logic h[$], input logic lvl);
        if (h.size() < D) return lvl;
        for (int i = 0; i < D; i++)
            if (h[i] == lvl) return lvl;
        return !lvl;
    endfunction

    task automatic model_reset();
        s1a = 0; s2a = 0; s1d = 0; s2d = 0;
        deba = 0; debd = 0; preva = 0; prevd = 0;
        ha.delete(); hd.delete();
        mcnt = 0; ph = P_IDLE; serve_age = 0; movf = 0; mrr = 0;
    endtask

    task automatic model_edge(input logic a, input logic d, input logic [1:0] c);
        logic ea, ed;
        exp_t e;
        ea = deba && !preva;
        ed = debd && !prevd;
        case (ph)
            P_IDLE:  if (mcnt != 0) ph = P_REQ;
            P_REQ:   if (c == 2'd2) begin ph = P_SERVE; serve_age = 1; end
            P_SERVE: if (mcnt == 0 || serve_age == MS) ph = P_DRAIN;
                     else serve_age++;
            default: if (c == 2'd0) ph = P_IDLE;
        endcase
        if (ea && !ed) begin
            if (mcnt == (1 << CW) - 1) movf = 1;
            else mcnt++;
        end else if (ed && !ea && mcnt > 0) begin
            mcnt--;
        end
        mrr   = ed && (c == 2'd0);
        preva = deba;
        prevd = debd;
        ha.push_back(s2a); if (ha.size() > D) void'(ha.pop_front());
        hd.push_back(s2d); if (hd.size() > D) void'(hd.pop_front());
        deba = window_level(ha, deba);
        debd = window_level(hd, debd);
        s2a = s1a; s1a = a;
        s2d = s1d; s1d = d;
        e.x   = (ph == P_REQ) || (ph == P_SERVE);
        e.cnt = mcnt;
        e.ovf = movf;
        e.rr  = mrr;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic a, input logic d, input logic [1:0] c);
        arr_raw = a; dep_raw = d; crd = c;
        @(posedge clk);
        #1;
        model_edge(a, d, c);
    endtask

    task automatic pulse(input logic a, input logic d, input logic [1:0] c);
        repeat (D + 1) step(a, d, c);
        repeat (D + 1) step(1'b0, 1'b0, c);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Assert reset mid-cycle and check outputs clear before any edge.
    task automatic do_reset();
        settle();
        arr_raw = 0; dep_raw = 0;
        clear_n = 0;
        #1;
        check("reset_x", int'(x), 0);
        check("reset_cnt", int'(queue_cnt), 0);
        check("reset_ovf", int'(overflow), 0);
        check("reset_rr", int'(red_run), 0);
        model_reset();
        repeat (2) @(posedge clk);
        settle();
        clear_n = 1;
    endtask

    // Monitor: one expected output set per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs{x,ovf,rr,cnt}",
                      int'({x, overflow, red_run, queue_cnt}),
                      int'({e.x, e.ovf, e.rr, CW'(e.cnt)}));
            end
        end
    end

    initial begin
        model_reset();
        #1;
        check("init_x", int'(x), 0);
        check("init_cnt", int'(queue_cnt), 0);
        check("init_ovf", int'(overflow), 0);
        repeat (2) @(posedge clk);
        settle();
        clear_n = 1;

        // Short glitch, then a held arrival
        repeat (3) step(1, 0, 0);
        repeat (12) step(0, 0, 0);
        check("glitch_cnt", int'(queue_cnt), 0);
        repeat (10) step(1, 0, 0);
        repeat (8) step(0, 0, 0);

        // Normal service cycle
        repeat (2) pulse(1, 0, 0);
        step(0, 0, 2);
        repeat (3) pulse(0, 1, 2);
        repeat (3) step(0, 0, 1);
        repeat (6) step(0, 0, 0);
        settle();
        check("normal_x", int'(x), 0);

        // Forced release with vehicles still waiting, then re-request
        repeat (2) pulse(1, 0, 0);
        repeat (40) step(0, 0, 2);
        repeat (4) step(0, 0, 0);

        // Red-run departures, then departure at an empty queue
        repeat (2) pulse(0, 1, 0);
        pulse(0, 1, 0);
        settle();
        check("empty_dep_cnt", int'(queue_cnt), 0);

        // Simultaneous arrival and departure
        pulse(1, 0, 0);
        pulse(1, 1, 0);
        settle();
        check("simul_cnt", int'(queue_cnt), 1);

        // Saturate the queue
        repeat (16) pulse(1, 0, 0);
        settle();
        check("sat_cnt", int'(queue_cnt), 15);
        check("sat_ovf", int'(overflow), 1);

        // Drain to 5, enter SERVE, reset mid-service
        repeat (10) pulse(0, 1, 0);
        repeat (3) step(0, 0, 2);
        settle();
        check("pre_reset_cnt", int'(queue_cnt), 5);
        do_reset();
        repeat (10) step(0, 0, 0);

        // Randomized segments
        repeat (200) begin
            logic       a, d;
            logic [1:0] c;
            int         len;
            a   = 1'($urandom_range(0, 1));
            d   = 1'($urandom_range(0, 1));
            c   = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 12);
            repeat (len) step(a, d, c);
        end

        settle();
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/traffic_sensor_interface.md
Name: traffic_sensor_interface

Overview:
- Country-road vehicle sensing front end that generates the car-present request `x` consumed by the traffic signal controller.
- Conditions two raw inductive-loop inputs: an arrival loop upstream and a departure loop at the stop line.
- Maintains a waiting-vehicle count.
- Drives `x` through a request/serve handshake against the controller's country-road light output `crd`, with a maximum-serve limit for highway fairness.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required before a debounced loop level changes (≥1).
- CNT_W, 4: width of the vehicle queue counter.
- MAX_SERVE, 32: maximum cycles `x` is held in SERVE before a forced release (≥1).

Ports:
- clk  in  1  system clock
- clear_n  in  1  reset, asynchronous, active-low
- arr_raw  in  1  arrival loop detector, asynchronous to clk, high = vehicle over loop
- dep_raw  in  1  departure loop detector, asynchronous to clk
- crd  in  2  country-road light from controller: 0=RED, 1=YELLOW, 2=GREEN, 3=invalid
- x  out  1  vehicle request to controller, registered
- queue_cnt  out  CNT_W  vehicles waiting, registered
- overflow  out  1  sticky: an arrival was lost at a full queue
- red_run  out  1  one-cycle pulse: departure detected while crd==RED

Behaviour:
- Reset (clear_n low, asynchronous, any time including mid-operation):
  - x=0, queue_cnt=0, overflow=0, red_run=0.
  - FSM = IDLE; synchronizers, debounced levels and all counters = 0.
  - Release is synchronous to clk.
- Input conditioning:
  - Each raw input passes through a 2-flop synchronizer.
  - The debounced level changes only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive clk edges. Any mismatch-free sample resets the debounce counter.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Events:
  - The arrival event is the rising edge of debounced arrival; the departure event is the rising edge of debounced departure. Each is one cycle.
  - Falling edges are ignored.
- Latency:
  - With arr_raw rising stable before edge 1, queue_cnt increments at edge 3+DEBOUNCE_CYCLES.
  - x asserts (from IDLE) one edge later.
  - Departure has the same latency.
- Queue counter, per cycle:
  - arrival only: +1
  - departure only: -1
  - both: unchanged
  - arrival at all-ones: count holds, overflow set (sticky until reset)
  - departure at 0: ignored, count holds at 0, no wrap
- red_run:
  - Pulses in the cycle after a departure event seen while crd==0.
  - The departure still decrements the count.
- Request FSM (x registered, x=1 exactly in REQ and SERVE):
  - IDLE: queue_cnt≠0 → REQ.
  - REQ: crd==2 → SERVE, serve timer cleared; otherwise stay.
  - SERVE:
    - queue_cnt==0 → DRAIN.
    - serve timer reaches MAX_SERVE-1 → DRAIN (forced release, even with vehicles waiting).
    - Otherwise increment the timer.
    - Queue-empty and timeout in the same cycle → DRAIN.
  - DRAIN: x=0; crd==0 → IDLE; otherwise stay. From IDLE, a non-empty queue re-requests on the next edge.
- crd==3 is neither GREEN nor RED: REQ and DRAIN hold, SERVE continues timing.
- queue_cnt changes in every state; only the FSM reads it.

Test Plan:
- Reset/idle: clear_n low mid-SERVE with queue_cnt=5 → x=0, queue_cnt=0, overflow=0 immediately (before next edge); after release, x stays 0 with no loop activity.
- Debounce: arr_raw high for 3 cycles (DEBOUNCE_CYCLES=4) → queue_cnt stays 0. Held 10 cycles → queue_cnt=1 at edge 7, x=1 at edge 8.
- Normal cycle: 3 arrivals, crd driven 0→2 → FSM REQ→SERVE. Then 3 departures → queue_cnt=0, x drops next edge. crd→1→0 → IDLE, x stays 0.
- Forced release: 2 arrivals, crd=2 held, no departures → x falls after exactly MAX_SERVE=32 cycles in SERVE. crd→0 → x re-asserts next edge (queue_cnt=2).
- Counter boundaries:
  - 16 arrivals at CNT_W=4 → queue_cnt=15, overflow=1.
  - Departure at queue_cnt=0 → stays 0.
  - Simultaneous arrival and departure events → count unchanged.
- Red-run: departure event with crd=0 → red_run one-cycle pulse, queue_cnt decrements by 1.
